// File: rtl/rmw_counter_pipe.sv
// Read-modify-write counter pipeline over a 2^AW x DW synchronous-read memory, with hazard
// forwarding and power-on memory clear. Define RMW_SAT_EN to saturate INC results.
module rmw_counter_pipe #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16,
    parameter int unsigned IW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [IW-1:0] cmd_inc,
    output logic          rsp_valid,
    output logic [1:0]    rsp_op,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_sat
);

    localparam int unsigned Depth = 1 << AW;
    localparam logic [1:0] OpInc   = 2'b00;
    localparam logic [1:0] OpClear = 2'b10;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ic_q, ic_d;

    logic          s1_valid_q, s1_valid_d;
    logic [1:0]    s1_op_q, s1_op_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic [IW-1:0] s1_inc_q, s1_inc_d;

    logic          s2_valid_q, s2_valid_d;
    logic [1:0]    s2_op_q, s2_op_d;
    logic [AW-1:0] s2_addr_q, s2_addr_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic          s2_sat_q, s2_sat_d;

    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d;

    logic [DW-1:0] mem_q [Depth];
    logic [DW-1:0] mem_rdata_q;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic          s2_is_write;
    logic [DW-1:0] operand;
    logic [DW-1:0] inc_result;
    logic          inc_sat;

    assign cmd_ready   = (state_q == StRun);
    assign s2_is_write = (s2_op_q == OpInc) || (s2_op_q == OpClear);

    always_comb begin
        state_d = state_q;
        ic_d    = ic_q;
        if (state_q == StInit) begin
            ic_d = ic_q + 1'b1;
            if (ic_q == {AW{1'b1}}) begin
                state_d = StRun;
            end
        end
    end

    // INIT owns the write port; in RUN only the S2 stage writes back.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s2_addr_q;
        mem_wdata = s2_data_q;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_waddr = ic_q;
            mem_wdata = '0;
        end else if (s2_valid_q && s2_is_write) begin
            mem_we = 1'b1;
        end
    end

    // Contents are not reset; INIT defines them. Read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        mem_rdata_q <= mem_q[cmd_addr];
    end

    always_comb begin
        s1_valid_d = cmd_valid && cmd_ready;
        s1_op_d    = s1_op_q;
        s1_addr_d  = s1_addr_q;
        s1_inc_d   = s1_inc_q;
        if (s1_valid_d) begin
            s1_op_d   = cmd_op;
            s1_addr_d = cmd_addr;
            s1_inc_d  = cmd_inc;
        end
    end

    // S2 write lands on the edge that loads S1's result; WB landed on S1's read edge.
    always_comb begin
        operand = mem_rdata_q;
        if (s2_valid_q && s2_is_write && (s2_addr_q == s1_addr_q)) begin
            operand = s2_data_q;
        end else if (wb_valid_q && (wb_addr_q == s1_addr_q)) begin
            operand = wb_data_q;
        end
    end

`ifdef RMW_SAT_EN
    logic [DW:0] inc_sum;
    assign inc_sum    = {1'b0, operand} + (DW+1)'(s1_inc_q);
    assign inc_sat    = inc_sum[DW];
    assign inc_result = inc_sum[DW] ? {DW{1'b1}} : inc_sum[DW-1:0];
`else
    assign inc_result = operand + DW'(s1_inc_q);
    assign inc_sat    = 1'b0;
`endif

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_op_d    = s2_op_q;
        s2_addr_d  = s2_addr_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s1_valid_q) begin
            s2_op_d   = s1_op_q;
            s2_addr_d = s1_addr_q;
            s2_sat_d  = 1'b0;
            case (s1_op_q)
                OpInc: begin
                    s2_data_d = inc_result;
                    s2_sat_d  = inc_sat;
                end
                OpClear: s2_data_d = '0;
                default: s2_data_d = operand;
            endcase
        end
    end

    always_comb begin
        wb_valid_d = s2_valid_q && s2_is_write;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (wb_valid_d) begin
            wb_addr_d = s2_addr_q;
            wb_data_d = s2_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            ic_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_addr_q  <= '0;
            s1_inc_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_op_q    <= '0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ic_q       <= ic_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_addr_q  <= s1_addr_d;
            s1_inc_q   <= s1_inc_d;
            s2_valid_q <= s2_valid_d;
            s2_op_q    <= s2_op_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_op    = s2_op_q;
    assign rsp_addr  = s2_addr_q;
    assign rsp_data  = s2_data_q;
    assign rsp_sat   = s2_sat_q;

endmodule

// File: tb/tb_rmw_counter_pipe.sv
// Directed, table-driven bench for rmw_counter_pipe at AW=8, DW=8, IW=8.
// Saturation expectations follow RMW_SAT_EN as seen by this compile.
module tb_rmw_counter_pipe;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 8;

    localparam logic [1:0] OpInc   = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpClear = 2'b10;

`ifdef RMW_SAT_EN
    localparam logic [7:0] SecondSumData = 8'd255;
    localparam logic       SecondSumSat  = 1'b1;
`else
    localparam logic [7:0] SecondSumData = 8'd144;
    localparam logic       SecondSumSat  = 1'b0;
`endif

    typedef struct {
        logic          v;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [IW-1:0] inc;
        logic [DW-1:0] exp_data;
        logic          exp_sat;
    } vec_t;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          sat;
        int            cyc;
    } rsp_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [IW-1:0] cmd_inc;
    logic          rsp_valid;
    logic [1:0]    rsp_op;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_sat;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    vec_t vecs[$];
    rsp_t rsp_q[$];
    int   acc_q[$];

    rmw_counter_pipe #(.AW(AW), .DW(DW), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_inc   (cmd_inc),
        .rsp_valid (rsp_valid),
        .rsp_op    (rsp_op),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .rsp_sat   (rsp_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (rsp_valid) rsp_q.push_back('{rsp_op, rsp_addr, rsp_data, rsp_sat, cyc});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic v, input logic [1:0] op, input logic [7:0] addr,
                       input logic [7:0] inc, input logic [7:0] d, input logic s);
        vecs.push_back('{v, op, addr, inc, d, s});
    endtask

    // Bounded wait for cmd_ready; drives ignored commands during the first part of INIT.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = OpInc;
        cmd_addr  = 8'h10;
        cmd_inc   = 8'd7;
        while (!cmd_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 200) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk(name, n, 256);
        chk({name, "_no_rsp"}, rsp_q.size(), 0);
    endtask

    task automatic run_table(input string tag);
        int j;
        int n_exp;
        rsp_q.delete();
        acc_q.delete();
        n_exp = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            cmd_valid = vecs[i].v;
            cmd_op    = vecs[i].op;
            cmd_addr  = vecs[i].addr;
            cmd_inc   = vecs[i].inc;
            if (vecs[i].v) n_exp++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_rsp_count"}, rsp_q.size(), n_exp);
        j = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].v && j < rsp_q.size() && j < acc_q.size()) begin
                chk($sformatf("%s_v%0d_data", tag, i), rsp_q[j].data, vecs[i].exp_data);
                chk($sformatf("%s_v%0d_op_addr_sat", tag, i),
                    {rsp_q[j].op, rsp_q[j].addr, rsp_q[j].sat},
                    {vecs[i].op, vecs[i].addr, vecs[i].exp_sat});
                chk($sformatf("%s_v%0d_latency", tag, i), rsp_q[j].cyc - acc_q[j], 2);
                j++;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_inc   = '0;
        #13;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_fields", {rsp_op, rsp_addr, rsp_data, rsp_sat}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init1_len");

        add(1, OpRead,  8'h00, 0,   0,   0);
        add(1, OpRead,  8'hFF, 0,   0,   0);
        for (int k = 1; k <= 5; k++) add(1, OpInc, 8'h10, 1, 8'(k), 0);
        add(1, OpRead,  8'h10, 0,   5,   0);
        add(1, OpInc,   8'h40, 3,   3,   0);
        add(1, OpInc,   8'h41, 1,   1,   0);
        add(1, OpInc,   8'h40, 4,   7,   0);
        add(0, OpRead,  8'h00, 0,   0,   0);
        add(0, OpRead,  8'h00, 0,   0,   0);
        add(0, OpRead,  8'h00, 0,   0,   0);
        add(1, OpRead,  8'h40, 0,   7,   0);
        add(1, OpRead,  8'h41, 0,   1,   0);
        add(1, OpInc,   8'h20, 200, 200, 0);
        add(1, OpInc,   8'h20, 200, SecondSumData, SecondSumSat);
        add(1, OpInc,   8'h30, 9,   9,   0);
        add(1, OpClear, 8'h30, 5,   0,   0);
        add(1, OpInc,   8'h30, 2,   2,   0);
        add(1, 2'b11,   8'h30, 0,   2,   0);
        add(0, OpRead,  8'h00, 0,   0,   0);
        add(1, OpInc,   8'h30, 1,   3,   0);
        add(1, OpRead,  8'h20, 0,   SecondSumData, 0);
        run_table("main");

        // Two INCs in flight when reset hits: neither may respond nor commit.
        rsp_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = OpInc;
        cmd_addr  = 8'h50;
        cmd_inc   = 8'd5;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init2_len");

        vecs.delete();
        add(1, OpRead, 8'h50, 0, 0, 0);
        add(1, OpRead, 8'h10, 0, 0, 0);
        add(1, OpRead, 8'h40, 0, 0, 0);
        add(1, OpInc,  8'h30, 6, 6, 0);
        run_table("post");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
